// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: serial/parallel load, logical/arithmetic/rotate
// shifts, plus a counted burst-shift engine with busy/done handshake.
module universal_shift_register #(
    parameter  int WIDTH = 4,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             x,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHL  = 3'b001,
        M_SHR  = 3'b010,
        M_ROL  = 3'b011,
        M_ROR  = 3'b100,
        M_LOAD = 3'b101,
        M_CLR  = 3'b110,
        M_ASR  = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              sout_q, sout_d;
    logic              done_q, done_d;
    logic [AW-1:0]     amt_clamped;

    // Returns {sout, out} after applying one operation of mode m.
    function automatic logic [WIDTH:0] step(input mode_e m, input logic [WIDTH-1:0] v,
                                            input logic si, input logic so,
                                            input logic [WIDTH-1:0] ld);
        case (m)
            M_SHL:   return {v[WIDTH-1], v[WIDTH-2:0], si};
            M_SHR:   return {v[0], si, v[WIDTH-1:1]};
            M_ROL:   return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   return {v[0], v[0], v[WIDTH-1:1]};
            M_LOAD:  return {so, ld};
            M_CLR:   return {so, {WIDTH{1'b0}}};
            M_ASR:   return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: return {so, v};
        endcase
    endfunction

    function automatic logic is_shift(input mode_e m);
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) || (m == M_ROR) || (m == M_ASR);
    endfunction

    assign amt_clamped = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d = mode_e'(mode);
                        cnt_d  = amt_clamped;
                        if (is_shift(mode_e'(mode)) && (amt_clamped != '0))
                            state_d = RUN;
                        else
                            done_d = 1'b1;
                    end else begin
                        {sout_d, out_d} = step(mode_e'(mode), out_q, x, sout_q, d);
                    end
                end
                RUN: begin
                    {sout_d, out_d} = step(mode_q, out_q, x, sout_q, d);
                    cnt_d = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            out_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign sout = sout_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=4); each check compares
// {out, sout, busy, done} against a hand-computed vector.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst, en, x, start;
    logic [2:0] mode;
    logic [3:0] d;
    logic [2:0] amount;
    logic [3:0] out;
    logic       sout, busy, done;
    logic [6:0] obs;
    int         total = 0;
    int         bad = 0;

    universal_shift_register #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .d(d),
        .start(start), .amount(amount), .out(out), .sout(sout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {out, sout, busy, done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v, input logic [6:0] exp);
        mode = 3'b101; d = v; start = 0;
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL load got=%b want=%b", obs, exp); end
        mode = 3'b000;
    endtask

    task automatic test_reset();
        rst = 0; en = 1; mode = 3'b001; x = 1; start = 0; d = '0; amount = '0;
        tick(); tick();
        total++;
        if (obs !== 7'b0000_0_0_0) begin bad++; $display("FAIL reset got=%b want=%b", obs, 7'b0000000); end
        rst = 1; mode = 3'b000;
    endtask

    task automatic test_serial_fill();
        logic [6:0] exp [5] = '{7'b0001_0_00, 7'b0011_0_00, 7'b0111_0_00, 7'b1111_0_00, 7'b1110_1_00};
        mode = 3'b001;
        for (int i = 0; i < 5; i++) begin
            x = (i < 4);
            tick();
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL fill%0d got=%b want=%b", i, obs, exp[i]); end
        end
        mode = 3'b000;
    endtask

    task automatic test_load_shift();
        logic [2:0] m   [5] = '{3'b100, 3'b111, 3'b010, 3'b011, 3'b110};
        logic [6:0] exp [5] = '{7'b1101_1_00, 7'b1101_1_00, 7'b0101_1_00, 7'b0111_1_00, 7'b0000_1_00};
        x = 0;
        for (int i = 0; i < 5; i++) begin
            load(4'b1011, 7'b1011_1_00);
            mode = m[i];
            tick();
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL shift%0d got=%b want=%b", i, obs, exp[i]); end
        end
        mode = 3'b000;
        tick();
        total++;
        if (obs !== 7'b0000_1_00) begin bad++; $display("FAIL hold got=%b want=%b", obs, 7'b0000100); end
    endtask

    task automatic test_burst();
        logic [2:0] m   [4] = '{3'b101, 3'b110, 3'b000, 3'b000};
        logic [6:0] exp [4] = '{7'b0010_0_10, 7'b0100_0_10, 7'b1000_0_01, 7'b1000_0_00};
        load(4'b0001, 7'b0001_1_00);
        start = 1; mode = 3'b011; amount = 3;
        tick();
        total++;
        if (obs !== 7'b0001_1_10) begin bad++; $display("FAIL burst_cap got=%b want=%b", obs, 7'b0001110); end
        start = 0; d = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            mode = m[i];
            tick();
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL burst%0d got=%b want=%b", i, obs, exp[i]); end
        end
    endtask

    task automatic test_clamp();
        logic [6:0] exp [6] = '{7'b1011_0_10, 7'b1101_1_10, 7'b1110_1_10, 7'b0111_0_10,
                                7'b1011_1_01, 7'b1011_1_00};
        load(4'b1011, 7'b1011_0_00);
        start = 1; mode = 3'b100; amount = 7;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 0; mode = 3'b000;
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL clamp%0d got=%b want=%b", i, obs, exp[i]); end
        end
    endtask

    task automatic test_pause();
        logic       e   [8] = '{1, 1, 0, 0, 1, 1, 1, 0};
        logic [6:0] exp [8] = '{7'b0001_1_10, 7'b0010_0_10, 7'b0010_0_10, 7'b0010_0_10,
                                7'b0100_0_10, 7'b1000_0_10, 7'b0000_1_01, 7'b0000_1_00};
        load(4'b0001, 7'b0001_1_00);
        start = 1; mode = 3'b001; x = 0; amount = 4;
        for (int i = 0; i < 8; i++) begin
            en = e[i];
            tick();
            start = 0; mode = 3'b000;
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL pause%0d got=%b want=%b", i, obs, exp[i]); end
        end
        en = 1;
    endtask

    task automatic test_start_during_busy();
        load(4'b0001, 7'b0001_1_00);
        start = 1; mode = 3'b011; amount = 2;
        tick();
        total++;
        if (obs !== 7'b0001_1_10) begin bad++; $display("FAIL sdb_cap got=%b want=%b", obs, 7'b0001110); end
        start = 1; mode = 3'b100; amount = 4;
        tick();
        total++;
        if (obs !== 7'b0010_0_10) begin bad++; $display("FAIL sdb_s1 got=%b want=%b", obs, 7'b0010010); end
        tick();
        total++;
        if (obs !== 7'b0100_0_01) begin bad++; $display("FAIL sdb_s2 got=%b want=%b", obs, 7'b0100001); end
        start = 0; mode = 3'b000;
        tick();
        total++;
        if (obs !== 7'b0100_0_00) begin bad++; $display("FAIL sdb_end got=%b want=%b", obs, 7'b0100000); end
    endtask

    task automatic test_degenerate();
        load(4'b1011, 7'b1011_0_00);
        start = 1; mode = 3'b001; amount = 0;
        tick();
        total++;
        if (obs !== 7'b1011_0_01) begin bad++; $display("FAIL zero_amt got=%b want=%b", obs, 7'b1011001); end
        mode = 3'b101; d = 4'b0000; amount = 3;
        tick();
        total++;
        if (obs !== 7'b1011_0_01) begin bad++; $display("FAIL nonshift got=%b want=%b", obs, 7'b1011001); end
        start = 0; mode = 3'b000;
        tick();
        total++;
        if (obs !== 7'b1011_0_00) begin bad++; $display("FAIL degen_end got=%b want=%b", obs, 7'b1011000); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp [4] = '{7'b0001_0_10, 7'b0010_0_01, 7'b0010_0_10, 7'b0100_0_01};
        load(4'b0001, 7'b0001_0_00);
        start = 1; mode = 3'b011; amount = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) start = 0;
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL b2b%0d got=%b want=%b", i, obs, exp[i]); end
        end
        mode = 3'b000;
    endtask

    task automatic test_reset_mid_burst();
        logic [6:0] exp [5] = '{7'b0001_0_10, 7'b0010_0_10, 7'b0100_0_10, 7'b0000_0_00, 7'b0000_0_00};
        load(4'b0001, 7'b0001_0_00);
        start = 1; mode = 3'b011; amount = 4;
        for (int i = 0; i < 5; i++) begin
            rst = (i != 3);
            tick();
            start = 0;
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL rstmid%0d got=%b want=%b", i, obs, exp[i]); end
        end
        rst = 1; mode = 3'b000;
        load(4'b0001, 7'b0001_0_00);
        start = 1; mode = 3'b011; amount = 2;
        tick();
        start = 0; mode = 3'b000;
        total++;
        if (obs !== 7'b0001_0_10) begin bad++; $display("FAIL rerun_cap got=%b want=%b", obs, 7'b0001010); end
        tick();
        tick();
        total++;
        if (obs !== 7'b0100_0_01) begin bad++; $display("FAIL rerun_end got=%b want=%b", obs, 7'b0100001); end
    endtask

    initial begin
        test_reset();
        test_serial_fill();
        test_load_shift();
        test_burst();
        test_clamp();
        test_pause();
        test_start_during_busy();
        test_degenerate();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
